text_buffer_ctrl: RTL and testbench



---
 rtl/text_buf_pkg.sv | 21 ++
 rtl/text_buffer_ctrl.sv | 133 +++++++++++++
 tb/tb_text_buffer_ctrl.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/text_buf_pkg.sv
// Shared constants and enumerations for the text buffer write-side controller.
package text_buf_pkg;

  localparam int         COLS       = 32;
  localparam int         ROWS       = 16;
  localparam logic [4:0] BLANK_CODE = 5'd26;

  typedef enum logic [1:0] {
    CLEAR     = 2'd0,
    BACKSPACE = 2'd1,
    NEWLINE   = 2'd2,
    HOME      = 2'd3
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CLEAR_ALL = 2'd1,
    CLEAR_ROW = 2'd2
  } state_t;

endpackage

// File: rtl/text_buffer_ctrl.sv
// Write-port owner for the 32x16 character buffer: arbitrates the char stream and
// editing commands, tracks the cursor and runs the bulk blank-fills.
module text_buffer_ctrl #(
  parameter int         COLS_LOG2  = 5,
  parameter int         ROWS_LOG2  = 4,
  parameter logic [4:0] BLANK_CODE = 5'd26
) (
  input  logic                           clk_in,
  input  logic                           rst_n_in,
  input  logic                           char_valid_in,
  input  logic [4:0]                     char_in,
  output logic                           char_ready_out,
  input  logic                           cmd_valid_in,
  input  logic [1:0]                     cmd_in,
  output logic                           cmd_ready_out,
  output logic                           wr_en_out,
  output logic [COLS_LOG2+ROWS_LOG2-1:0] wr_addr_out,
  output logic [4:0]                     wr_data_out,
  output logic [COLS_LOG2+ROWS_LOG2-1:0] cursor_out,
  output logic                           busy_out
);
  import text_buf_pkg::*;

  localparam int AW = COLS_LOG2 + ROWS_LOG2;

  state_t                 state_q;
  logic [AW-1:0]          cnt_q;
  logic [AW-1:0]          cursor_q;
  logic                   wr_en_q;
  logic [AW-1:0]          wr_addr_q;
  logic [4:0]             wr_data_q;

  logic [ROWS_LOG2-1:0]   row;
  logic [COLS_LOG2-1:0]   col;
  logic [ROWS_LOG2-1:0]   row_inc;
  logic [AW-1:0]          next_row_base_d;
  logic [AW-1:0]          cursor_inc_d;
  logic [AW-1:0]          cursor_dec_d;

  assign {row, col}      = cursor_q;
  assign row_inc         = row + ROWS_LOG2'(1);
  assign next_row_base_d = {row_inc, {COLS_LOG2{1'b0}}};
  assign cursor_inc_d    = cursor_q + AW'(1);
  assign cursor_dec_d    = cursor_q - AW'(1);

  // Codes above the blank glyph have no sprite; render them as empty cells.
  function automatic logic [4:0] glyph(input logic [4:0] code);
    return (code > BLANK_CODE) ? BLANK_CODE : code;
  endfunction

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= CLEAR_ALL;
      cnt_q     <= '0;
      cursor_q  <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= BLANK_CODE;
    end else begin
      wr_en_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid_in) begin
            case (cmd_t'(cmd_in))
              CLEAR: begin
                wr_en_q   <= 1'b1;
                wr_addr_q <= '0;
                wr_data_q <= BLANK_CODE;
                cursor_q  <= '0;
                cnt_q     <= AW'(1);
                state_q   <= CLEAR_ALL;
              end
              BACKSPACE: begin
                if (col != '0) begin
                  wr_en_q   <= 1'b1;
                  wr_addr_q <= cursor_dec_d;
                  wr_data_q <= BLANK_CODE;
                  cursor_q  <= cursor_dec_d;
                end
              end
              NEWLINE: begin
                cursor_q <= next_row_base_d;
                cnt_q    <= '0;
                state_q  <= CLEAR_ROW;
              end
              HOME: cursor_q <= '0;
              default: ;
            endcase
          end else if (char_valid_in) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= cursor_q;
            wr_data_q <= glyph(char_in);
            if (&col) begin
              cursor_q <= next_row_base_d;
              cnt_q    <= '0;
              state_q  <= CLEAR_ROW;
            end else begin
              cursor_q <= cursor_inc_d;
            end
          end
        end
        CLEAR_ALL: begin
          wr_en_q   <= 1'b1;
          wr_addr_q <= cnt_q;
          wr_data_q <= BLANK_CODE;
          cnt_q     <= cnt_q + AW'(1);
          if (&cnt_q) state_q <= IDLE;
        end
        CLEAR_ROW: begin
          // Cursor already points at the row base, so it doubles as the fill base.
          wr_en_q   <= 1'b1;
          wr_addr_q <= {row, cnt_q[COLS_LOG2-1:0]};
          wr_data_q <= BLANK_CODE;
          cnt_q     <= cnt_q + AW'(1);
          if (&cnt_q[COLS_LOG2-1:0]) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready_out  = (state_q == IDLE);
  assign char_ready_out = (state_q == IDLE) && !cmd_valid_in;
  assign busy_out       = (state_q != IDLE);
  assign wr_en_out      = wr_en_q;
  assign wr_addr_out    = wr_addr_q;
  assign wr_data_out    = wr_data_q;
  assign cursor_out     = cursor_q;

endmodule

// File: tb/tb_text_buffer_ctrl.sv
// Self-checking bench for text_buffer_ctrl against a cursor/fill reference model.
module tb_text_buffer_ctrl;

  logic       clk_in = 1'b0;
  logic       rst_n_in = 1'b1;
  logic       char_valid_in = 1'b0;
  logic [4:0] char_in = '0;
  logic       cmd_valid_in = 1'b0;
  logic [1:0] cmd_in = '0;
  logic       char_ready_out, cmd_ready_out, wr_en_out, busy_out;
  logic [8:0] wr_addr_out, cursor_out;
  logic [4:0] wr_data_out;

  int checks = 0;
  int errors = 0;
  int mc = 0;
  logic [4:0] ref_mem [512];
  logic [4:0] dut_mem [512];

  text_buffer_ctrl dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .char_valid_in(char_valid_in), .char_in(char_in), .char_ready_out(char_ready_out),
    .cmd_valid_in(cmd_valid_in), .cmd_in(cmd_in), .cmd_ready_out(cmd_ready_out),
    .wr_en_out(wr_en_out), .wr_addr_out(wr_addr_out), .wr_data_out(wr_data_out),
    .cursor_out(cursor_out), .busy_out(busy_out)
  );

  always #5 clk_in = ~clk_in;

  // Emulates the buffer RAM that sits on the write port.
  always @(posedge clk_in)
    if (rst_n_in === 1'b1 && wr_en_out === 1'b1) dut_mem[wr_addr_out] <= wr_data_out;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    int busy_cycles;
    char_valid_in = 1'b0;
    cmd_valid_in  = 1'b0;
    rst_n_in = 1'b0;
    #2;
    checks++;
    if (wr_en_out !== 1'b0 || wr_addr_out !== 9'd0 || wr_data_out !== 5'd26 || cursor_out !== 9'd0 ||
        busy_out !== 1'b1 || char_ready_out !== 1'b0 || cmd_ready_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: en=%0b addr=%0d data=%0d cur=%0d busy=%0b crdy=%0b mrdy=%0b, want 0 0 26 0 1 0 0",
               wr_en_out, wr_addr_out, wr_data_out, cursor_out, busy_out, char_ready_out, cmd_ready_out);
    end
    step();
    step();
    rst_n_in = 1'b1;
    busy_cycles = (busy_out === 1'b1) ? 1 : 0;
    for (int i = 0; i < 512; i++) begin
      step();
      checks++;
      if (wr_en_out !== 1'b1 || wr_addr_out !== 9'(i) || wr_data_out !== 5'd26 || cursor_out !== 9'd0) begin
        errors++;
        $display("FAIL reset_clear[%0d]: en=%0b addr=%0d data=%0d cur=%0d, want 1 %0d 26 0",
                 i, wr_en_out, wr_addr_out, wr_data_out, cursor_out, i);
      end
      if (busy_out === 1'b1) busy_cycles++;
    end
    checks++;
    if (busy_cycles != 512) begin
      errors++;
      $display("FAIL reset_busy_len: got %0d cycles, want 512", busy_cycles);
    end
    checks++;
    if (char_ready_out !== 1'b1 || cmd_ready_out !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: crdy=%0b mrdy=%0b, want 1 1", char_ready_out, cmd_ready_out);
    end
    step();
    checks++;
    if (wr_en_out !== 1'b0 || busy_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: en=%0b busy=%0b, want 0 0", wr_en_out, busy_out);
    end
    for (int i = 0; i < 512; i++) ref_mem[i] = 5'd26;
    mc = 0;
  endtask

  // One accepted transfer from idle, checked cycle by cycle against the cursor model.
  task automatic do_op(input bit is_cmd, input logic [1:0] cmd, input logic [4:0] code, input bit both);
    int row, col, nmc, fill_base, fill_len, acc_addr, waitc;
    bit acc_wr;
    logic [4:0] acc_data;
    waitc = 0;
    while (busy_out !== 1'b0 && waitc < 1000) begin
      step();
      waitc++;
    end
    checks++;
    if (waitc >= 1000) begin
      errors++;
      $display("FAIL op_wait_idle: busy=%0b after %0d cycles, want 0", busy_out, waitc);
      return;
    end
    row = mc / 32;
    col = mc % 32;
    nmc = mc; acc_wr = 0; acc_addr = 0; acc_data = 5'd26; fill_base = 0; fill_len = 0;
    if (!is_cmd) begin
      acc_wr = 1; acc_addr = mc; acc_data = (code > 5'd26) ? 5'd26 : code;
      if (col == 31) begin
        nmc = ((row + 1) % 16) * 32; fill_base = nmc; fill_len = 32;
      end else nmc = mc + 1;
    end else begin
      case (cmd)
        2'd0: begin acc_wr = 1; acc_addr = 0; nmc = 0; fill_base = 1; fill_len = 511; end
        2'd1: if (col > 0) begin acc_wr = 1; acc_addr = mc - 1; nmc = mc - 1; end
        2'd2: begin nmc = ((row + 1) % 16) * 32; fill_base = nmc; fill_len = 32; end
        default: nmc = 0;
      endcase
    end
    if (is_cmd) begin
      cmd_valid_in = 1'b1; cmd_in = cmd; char_valid_in = both; char_in = code;
    end else begin
      char_valid_in = 1'b1; char_in = code;
    end
    #1;
    checks++;
    if (cmd_ready_out !== 1'b1 || char_ready_out !== !is_cmd) begin
      errors++;
      $display("FAIL op_ready: mrdy=%0b crdy=%0b, want 1 %0b", cmd_ready_out, char_ready_out, !is_cmd);
    end
    step();
    char_valid_in = 1'b0;
    cmd_valid_in  = 1'b0;
    checks++;
    if (wr_en_out !== acc_wr || (acc_wr && (wr_addr_out !== 9'(acc_addr) || wr_data_out !== acc_data)) ||
        cursor_out !== 9'(nmc) || busy_out !== (fill_len > 0)) begin
      errors++;
      $display("FAIL op_accept(cmd=%0b,op=%0d,code=%0d,cur=%0d): en=%0b addr=%0d data=%0d cur=%0d busy=%0b, want %0b %0d %0d %0d %0b",
               is_cmd, cmd, code, mc, wr_en_out, wr_addr_out, wr_data_out, cursor_out, busy_out,
               acc_wr, acc_addr, acc_data, nmc, fill_len > 0);
    end
    if (acc_wr) ref_mem[acc_addr] = acc_data;
    for (int k = 0; k < fill_len; k++) begin
      step();
      checks++;
      if (wr_en_out !== 1'b1 || wr_addr_out !== 9'(fill_base + k) || wr_data_out !== 5'd26 ||
          busy_out !== (k < fill_len - 1) || char_ready_out !== (k == fill_len - 1) || cursor_out !== 9'(nmc)) begin
        errors++;
        $display("FAIL op_fill[%0d]: en=%0b addr=%0d data=%0d busy=%0b crdy=%0b cur=%0d, want 1 %0d 26 %0b %0b %0d",
                 k, wr_en_out, wr_addr_out, wr_data_out, busy_out, char_ready_out, cursor_out,
                 fill_base + k, k < fill_len - 1, k == fill_len - 1, nmc);
      end
      ref_mem[fill_base + k] = 5'd26;
    end
    mc = nmc;
  endtask

  task automatic test_idle_quiet(input string name);
    step();
    checks++;
    if (wr_en_out !== 1'b0 || cursor_out !== 9'(mc) || busy_out !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: en=%0b cur=%0d busy=%0b, want 0 %0d 0", name, wr_en_out, cursor_out, busy_out, mc);
    end
  endtask

  task automatic test_back_to_back();
    do_op(1'b1, 2'd3, 5'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      char_valid_in = 1'b1;
      char_in = 5'(i);
      step();
      checks++;
      if (wr_en_out !== 1'b1 || wr_addr_out !== 9'(i) || wr_data_out !== 5'(i)) begin
        errors++;
        $display("FAIL b2b[%0d]: en=%0b addr=%0d data=%0d, want 1 %0d %0d", i, wr_en_out, wr_addr_out, wr_data_out, i, i);
      end
      ref_mem[i] = 5'(i);
    end
    char_valid_in = 1'b0;
    mc = 3;
    test_idle_quiet("b2b");
  endtask

  task automatic test_row_end();
    do_op(1'b1, 2'd3, 5'd0, 1'b0);
    for (int i = 0; i < 32; i++) do_op(1'b0, 2'd0, 5'($urandom_range(0, 25)), 1'b0);
    checks++;
    if (mc != 32) begin
      errors++;
      $display("FAIL row_end_cursor: model=%0d, want 32", mc);
    end
    test_idle_quiet("row_end");
  endtask

  task automatic test_backspace();
    do_op(1'b1, 2'd3, 5'd0, 1'b0);
    for (int i = 0; i < 5; i++) do_op(1'b0, 2'd0, 5'($urandom_range(0, 25)), 1'b0);
    do_op(1'b1, 2'd1, 5'd0, 1'b0);
    do_op(1'b1, 2'd3, 5'd0, 1'b0);
    do_op(1'b1, 2'd2, 5'd0, 1'b0);
    do_op(1'b1, 2'd1, 5'd0, 1'b0);
    test_idle_quiet("backspace");
  endtask

  task automatic test_newline_wrap();
    for (int i = 0; i < 16 && (mc / 32) != 15; i++) do_op(1'b1, 2'd2, 5'd0, 1'b0);
    do_op(1'b1, 2'd2, 5'd0, 1'b0);
    do_op(1'b0, 2'd0, 5'd29, 1'b0);
    test_idle_quiet("wrap");
  endtask

  task automatic test_priority();
    do_op(1'b0, 2'd0, 5'd7, 1'b0);
    do_op(1'b1, 2'd3, 5'd12, 1'b1);
    test_idle_quiet("priority");
  endtask

  task automatic test_random();
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        logic [1:0] c;
        c = 2'($urandom_range(0, 3));
        if (c == 2'd0 && $urandom_range(0, 3) != 0) c = 2'd1;
        do_op(1'b1, c, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      end else begin
        do_op(1'b0, 2'd0, 5'($urandom_range(0, 31)), 1'b0);
      end
    end
    test_idle_quiet("random");
  endtask

  task automatic test_buffer_contents();
    int bad;
    step();
    bad = 0;
    for (int i = 0; i < 512; i++) if (dut_mem[i] !== ref_mem[i]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL buffer_contents: %0d cells differ, want 0", bad);
    end
  endtask

  task automatic test_reset_mid_fill();
    do_op(1'b1, 2'd3, 5'd0, 1'b0);
    cmd_valid_in = 1'b1;
    cmd_in = 2'd2;
    step();
    cmd_valid_in = 1'b0;
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (wr_en_out !== 1'b1 || busy_out !== 1'b1) begin
      errors++;
      $display("FAIL midfill_active: en=%0b busy=%0b, want 1 1", wr_en_out, busy_out);
    end
    test_reset();
    do_op(1'b0, 2'd0, 5'd4, 1'b0);
    test_idle_quiet("after_reset");
  endtask

  initial begin
    #1;
    test_reset();
    test_back_to_back();
    test_row_end();
    test_backspace();
    test_newline_wrap();
    test_priority();
    test_random();
    test_buffer_contents();
    test_reset_mid_fill();
    test_buffer_contents();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
